// File: rtl/bongo_pad.sv
// Two-player drum pad front end: synchronizes and debounces four raw contacts, reports
// hits, and exposes a serial report register at 16'h4016 plus a live level view at 16'h4017.
module bongo_pad #(
    parameter int unsigned DB_LIMIT = 17900
) (
    input  logic        i_clk_cpu,
    input  logic        i_rst,
    input  logic [1:0]  i_right,
    input  logic [1:0]  i_left,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_data_in,
    input  logic        i_cpu_write,
    input  logic        i_cpu_read,
    output logic [7:0]  o_cpu_data_out,
    output logic [3:0]  o_pad_state,
    output logic [3:0]  o_hit
);

    localparam logic [15:0] AddrSerial = 16'h4016;
    localparam logic [15:0] AddrLevels = 16'h4017;
    localparam logic [15:0] CntLast    = 16'(DB_LIMIT - 1);

    logic [3:0] w_raw;
    logic [3:0] w_stable;
    logic [3:0] w_hit;
    logic [7:0] w_report;
    logic       w_wr_serial;
    logic       w_rd;
    logic       w_strobe_fall;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_stable_prev;
    logic [3:0] r_hit_flags;
    logic       r_strobe;
    logic [7:0] r_shift;
    logic [7:0] r_data_out;

    assign w_raw = {i_left, i_right};

    for (genvar g = 0; g < 4; g++) begin : g_pad
        logic [15:0] r_cnt;
        logic        r_stable;

        // Counter only runs while the synchronized level disagrees with the stable level.
        always_ff @(posedge i_clk_cpu) begin
            if (i_rst) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2[g] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CntLast) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign w_stable[g] = r_stable;
    end

    assign w_hit         = w_stable & ~r_stable_prev;
    assign w_report      = {r_hit_flags, w_stable};
    assign w_wr_serial   = i_cpu_write && (i_cpu_addr == AddrSerial);
    // A write wins over a simultaneous read.
    assign w_rd          = i_cpu_read && !i_cpu_write;
    assign w_strobe_fall = w_wr_serial && r_strobe && !i_cpu_data_in[0];

    always_ff @(posedge i_clk_cpu) begin
        if (i_rst) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_stable_prev <= '0;
            r_hit_flags   <= '0;
            r_strobe      <= 1'b0;
            r_shift       <= '0;
            r_data_out    <= '0;
        end else begin
            r_sync1       <= w_raw;
            r_sync2       <= r_sync1;
            r_stable_prev <= w_stable;

            if (w_wr_serial) begin
                r_strobe <= i_cpu_data_in[0];
            end

            // Hits landing in the latch cycle survive the clear.
            r_hit_flags <= (w_strobe_fall ? 4'b0000 : r_hit_flags) | w_hit;

            if (r_strobe) begin
                r_shift <= w_report;
            end else if (w_rd && (i_cpu_addr == AddrSerial)) begin
                r_shift <= {1'b1, r_shift[7:1]};
            end

            if (w_rd) begin
                case (i_cpu_addr)
                    AddrSerial: r_data_out <= {7'b0, r_strobe ? w_report[0] : r_shift[0]};
                    AddrLevels: r_data_out <= {4'b0, w_stable};
                    default:    r_data_out <= 8'h00;
                endcase
            end
        end
    end

    assign o_cpu_data_out = r_data_out;
    assign o_pad_state    = i_rst ? 4'b0000 : w_stable;
    assign o_hit          = i_rst ? 4'b0000 : w_hit;

endmodule

// File: tb/tb_bongo_pad.sv
// Scoreboard bench for bongo_pad with DB_LIMIT=4: reads push expected bytes, a monitor
// compares cpu_data_out; pad levels and hits are checked cycle by cycle.
module tb_bongo_pad;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  right;
    logic [1:0]  left;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_write;
    logic        cpu_read;
    logic [7:0]  cpu_data_out;
    logic [3:0]  pad_state;
    logic [3:0]  hit;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic       rd_pending = 1'b0;

    bongo_pad #(.DB_LIMIT(4)) dut (
        .i_clk_cpu      (clk),
        .i_rst          (rst),
        .i_right        (right),
        .i_left         (left),
        .i_cpu_addr     (cpu_addr),
        .i_cpu_data_in  (cpu_data_in),
        .i_cpu_write    (cpu_write),
        .i_cpu_read     (cpu_read),
        .o_cpu_data_out (cpu_data_out),
        .o_pad_state    (pad_state),
        .o_hit          (hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read accepted at a rising edge presents its data by the next falling edge.
    always @(posedge clk) rd_pending <= cpu_read && !cpu_write && !rst;

    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                chk("rd_underflow", cpu_data_out, 8'hxx);
            end else begin
                chk("rd_data", cpu_data_out, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr    = a;
        cpu_data_in = d;
        cpu_write   = 1'b1;
        @(negedge clk);
        cpu_write   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        cpu_addr = a;
        cpu_read = 1'b1;
        @(negedge clk);
        cpu_read = 1'b0;
    endtask

    // Serial reads of a latched byte, LSB first; past bit 7 the shifter returns 1.
    task automatic rd_seq(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            rd(16'h4016, (i < 8) ? {7'b0, b[i]} : 8'h01);
        end
    endtask

    // Inputs changed at the preceding falling edge; new level expected after 2+4 edges.
    task automatic qualify(input string name, input logic [3:0] exp_pad,
                           input logic [3:0] exp_hit, input logic [3:0] old_pad);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 6) begin
                chk({name, "_pad_wait"}, {4'b0, pad_state}, {4'b0, old_pad});
                chk({name, "_hit_wait"}, {4'b0, hit}, 8'h00);
            end else if (k == 6) begin
                chk({name, "_pad"}, {4'b0, pad_state}, {4'b0, exp_pad});
                chk({name, "_hit"}, {4'b0, hit}, {4'b0, exp_hit});
            end else begin
                chk({name, "_hit_end"}, {4'b0, hit}, 8'h00);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        right       = 2'b00;
        left        = 2'b00;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
        cpu_write   = 1'b0;
        cpu_read    = 1'b0;
        cyc(3);
        chk("rst_pad", {4'b0, pad_state}, 8'h00);
        chk("rst_hit", {4'b0, hit}, 8'h00);
        chk("rst_dout", cpu_data_out, 8'h00);
        rst = 1'b0;
        cyc(2);

        // Clean edge on right[0].
        right = 2'b01;
        qualify("r0", 4'b0001, 4'b0001, 4'b0000);

        // 3-cycle glitch on left[1] must be filtered.
        left = 2'b10;
        cyc(3);
        left = 2'b00;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("glitch_pad", {4'b0, pad_state}, 8'h01);
            chk("glitch_hit", {4'b0, hit}, 8'h00);
        end

        // left[1] held -> levels 1001, flags 1001.
        left = 2'b10;
        qualify("l1", 4'b1001, 4'b1000, 4'b0001);
        rd(16'h4017, 8'h09);

        // Latch {1001,1001} and read nine bits.
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        rd_seq(8'h99, 9);

        // Flags were cleared by the previous latch.
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        rd_seq(8'h09, 8);

        // left[0] hit lands exactly in the latch cycle and must survive the clear.
        left = 2'b11;
        cyc(5);
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        rd_seq(8'h0D, 8);
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        rd_seq(8'h4D, 8);

        // Strobe held high: reads return live bit 0 without shifting.
        left = 2'b00;
        cyc(7);
        chk("drop_pad", {4'b0, pad_state}, 8'h01);
        wr(16'h4016, 8'h01);
        rd(16'h4016, 8'h01);
        rd(16'h4016, 8'h01);
        rd(16'h4016, 8'h01);
        rd(16'h4017, 8'h01);

        // Write beats a simultaneous read.
        rd(16'h4000, 8'h00);
        cpu_addr    = 16'h4016;
        cpu_data_in = 8'h00;
        cpu_write   = 1'b1;
        cpu_read    = 1'b1;
        @(negedge clk);
        cpu_write   = 1'b0;
        cpu_read    = 1'b0;
        chk("collide_dout", cpu_data_out, 8'h00);
        rd_seq(8'h01, 2);
        wr(16'h4017, 8'h01);
        rd(16'h4016, 8'h00);
        rd(16'h4000, 8'h00);
        rd(16'h4017, 8'h01);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_dout", cpu_data_out, 8'h01);
        end

        // Reset mid-debounce with strobe set and shifter loaded.
        wr(16'h4016, 8'h01);
        left = 2'b10;
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pad", {4'b0, pad_state}, 8'h00);
        chk("midrst_hit", {4'b0, hit}, 8'h00);
        chk("midrst_dout", cpu_data_out, 8'h00);
        rst = 1'b0;
        qualify("requal", 4'b1001, 4'b1001, 4'b0000);
        rd(16'h4016, 8'h00);

        cyc(2);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bongo_pad.md
BONGO_PAD -- requirements
Module: bongo_pad

Interface
REQ-001 Parameter DB_LIMIT, default 17900, debounce hold time in clk_cpu cycles; legal range 2..65535.
REQ-002 clk_cpu  input  1  CPU-domain clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 right  input  2  raw, asynchronous right-drum contacts; active-high.
REQ-005 left  input  2  raw, asynchronous left-drum contacts; active-high.
REQ-006 cpu_addr  input  16  CPU address bus.
REQ-007 cpu_data_in  input  8  CPU write data.
REQ-008 cpu_write  input  1  single-cycle write strobe.
REQ-009 cpu_read  input  1  single-cycle read strobe.
REQ-010 cpu_data_out  output  8  registered read data.
REQ-011 pad_state  output  4  debounced pad levels, {left[1],left[0],right[1],right[0]} on bits 3..0.
REQ-012 hit  output  4  one-cycle pulse per pad on each debounced 0->1 transition; same bit order as pad_state.

Function
REQ-013 Each raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each pad SHALL have a 16-bit debounce counter, cleared whenever the synchronized value equals the stable value.
REQ-015 While the synchronized value differs from the stable value, the counter SHALL increment every cycle.
REQ-016 When the counter equals DB_LIMIT-1 and the values still differ, the stable value SHALL toggle and the counter SHALL clear in the same cycle.
REQ-017 Total input-to-pad_state latency SHALL be 2 + DB_LIMIT cycles for a clean edge; glitches shorter than DB_LIMIT cycles SHALL produce no change.
REQ-018 hit[i] SHALL be high for exactly the one cycle in which pad_state[i] first reads 1 after a 0->1 toggle; there SHALL be no pulse on 1->0.
REQ-019 A 4-bit sticky register, hit_flags, SHALL set bit i on hit[i].
REQ-020 The 8-bit report SHALL be {hit_flags, pad_state}.
REQ-021 A write to 16'h4016 SHALL load strobe <= cpu_data_in[0].
REQ-022 While strobe=1, the shift register SHALL reload with the live report every cycle.
REQ-023 On a write that changes strobe from 1 to 0, the shift register SHALL capture the report; hit_flags SHALL clear, except bits set by a hit in that same cycle, which SHALL remain set.
REQ-024 A read of 16'h4016 SHALL load cpu_data_out with {7'b0, shift[0]} on the next edge.
REQ-025 If strobe=0 during that read, the shift register SHALL shift right, filling bit 7 with 1, so reads 9 and later return 1.
REQ-026 If strobe=1 during a 16'h4016 read, the read SHALL return live report bit 0 and SHALL NOT shift.
REQ-027 A read of 16'h4017 SHALL return {4'b0, pad_state} with no side effects.
REQ-028 A read of any other address SHALL load cpu_data_out with 8'h00; writes to other addresses SHALL be ignored.
REQ-029 cpu_data_out SHALL hold its value when cpu_read=0.
REQ-030 If cpu_read and cpu_write are both asserted in the same cycle, the write SHALL take effect and the read SHALL be ignored; cpu_data_out and the shift register SHALL be unchanged by the read.

Reset
REQ-031 While rst=1: synchronizers, stable values, counters, hit_flags, strobe, shift register and cpu_data_out SHALL be 0; hit and pad_state SHALL read 0.
REQ-032 Reset asserted mid-debounce or mid-shift SHALL abort the operation; after release, a pad held high SHALL re-qualify after the full 2 + DB_LIMIT cycles.

Verification (bench DB_LIMIT=4)
REQ-033 right=2'b01 held -> pad_state=4'b0001 exactly 6 cycles later; hit[0] high 1 cycle; hit_flags=4'b0001.
REQ-034 left[1] pulse 3 cycles wide after sync -> pad_state and hit stay 0.
REQ-035 pad_state=4'b1001 with hit_flags=4'b1001; write 4016=1 then 4016=0; nine reads of 4016 -> bit0 sequence 1,0,0,1,1,0,0,1,1; hit_flags=0 afterwards.
REQ-036 strobe=1, pad_state=4'b0001; three reads of 4016 -> all return 8'h01, shift register not advanced.
REQ-037 Simultaneous cpu_write to 4016 (data 0) and cpu_read -> strobe=0, cpu_data_out unchanged; a read of 4017 -> {4'b0, pad_state}; a read of 4000 -> 8'h00.
REQ-038 rst pulsed during shift sequence and during debounce count -> all outputs 0 next cycle; held pad re-qualifies 6 cycles after release.
